// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU: WIDTH cycles per result (1 cycle on divide-by-zero).
// One request at a time; the result is held in DONE until out_ready, and flush aborts from any state.
module ex_div #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_next;
  logic [COUNT_W-1:0] cnt;
  logic [1:0]         op_q;
  logic               q_neg, r_neg;
  logic [WIDTH-1:0]   rem, quo, b_mag;

  logic               accept, is_signed, last;
  logic [WIDTH-1:0]   a_mag, b_in_mag;
  logic [WIDTH:0]     rem_sh, trial;
  logic [WIDTH-1:0]   rem_nx, quo_nx, q_fix, r_fix;

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_signed = !op[0];
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_in_mag  = (is_signed && b[WIDTH-1]) ? -b : b;

  // Partial remainder is always below the divisor, so WIDTH+1 bits cover the shifted trial.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, b_mag};
  assign rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign q_fix  = q_neg ? -quo_nx : quo_nx;
  assign r_fix  = r_neg ? -rem_nx : rem_nx;
  assign last   = (cnt == COUNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (b == '0) ? DONE : CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      op_q  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      b_mag <= '0;
      y     <= '0;
    end else if (accept) begin
      op_q  <= op;
      q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg <= is_signed & a[WIDTH-1];
      rem   <= '0;
      quo   <= a_mag;
      b_mag <= b_in_mag;
      cnt   <= '0;
      // Divide-by-zero skips the iterations: all-ones quotient, dividend as remainder.
      if (b == '0) y <= op[1] ? a : '1;
    end else if (state == CALC && !flush) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (last) y <= op_q[1] ? r_fix : q_fix;
    end
  end

endmodule
